// File: rtl/dlx_hazard_ctrl.sv
// DLX pipeline hazard controller: shadow scoreboard of in-flight destinations,
// ID stall / operand-A forwarding select, IF flush/hold and trap drain-to-halt.
module dlx_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dc_wait,
  input  logic [2:0]       id_opcode_class,
  input  logic [4:0]       id_ir_rs1,
  input  logic [4:0]       id_ir_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_wen,
  input  logic             id_cond,
  input  logic             id_halt,
  input  logic             id_illegal_instr,
  output logic             stall,
  output logic             id_a_fwd_sel,
  output logic             if_flush,
  output logic             if_hold,
  output logic             halted,
  output logic             illegal_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned DCNT_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [2:0] CLS_RR_ALU = 3'd0;
  localparam logic [2:0] CLS_IM_ALU = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;

  localparam logic FWDSEL_NONE           = 1'b0;
  localparam logic FWDSEL_EX_MEM_ALU_OUT = 1'b1;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       is_load;
  } sb_slot_t;

  // slot 0 = EX, 1 = MEM, 2 = WB
  sb_slot_t sb_q [3];
  sb_slot_t sb_d [3];

  logic [1:0]        state_q, state_d;
  logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic              halted_q, halted_d;
  logic              illegal_err_q, illegal_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  sb_slot_t ex_s, mem_s;
  logic     use_rs1, use_rs2, is_br, run, trap;
  logic     rs1_nz, rs2_nz, ex_hit1, ex_hit2, mem_hit1;

  assign ex_s  = sb_q[0];
  assign mem_s = sb_q[1];

  // Operand usage by instruction class.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_opcode_class)
      CLS_RR_ALU, CLS_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      CLS_IM_ALU, CLS_LOAD, CLS_BRANCH: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // Hazard detection, forwarding select and IF controls.
  always_comb begin
    is_br    = (id_opcode_class == CLS_BRANCH);
    run      = (state_q == ST_RUN);
    trap     = id_halt | id_illegal_instr;
    rs1_nz   = (id_ir_rs1 != 5'd0);
    rs2_nz   = (id_ir_rs2 != 5'd0);
    ex_hit1  = ex_s.vld & rs1_nz & (ex_s.rd == id_ir_rs1);
    ex_hit2  = ex_s.vld & rs2_nz & (ex_s.rd == id_ir_rs2);
    mem_hit1 = mem_s.vld & rs1_nz & (mem_s.rd == id_ir_rs1);

    stall = run & ((ex_s.is_load & ((use_rs1 & ex_hit1) | (use_rs2 & ex_hit2)))
                   | (is_br & ex_hit1)
                   | (is_br & mem_hit1 & mem_s.is_load));

    id_a_fwd_sel = (mem_hit1 & ~mem_s.is_load) ? FWDSEL_EX_MEM_ALU_OUT : FWDSEL_NONE;
    if_flush     = id_cond & ~stall & ~dc_wait & run;
    if_hold      = stall | dc_wait | ~run;
  end

  // Next state: scoreboard advance, FSM, counters; dc_wait freezes everything.
  always_comb begin
    sb_d          = sb_q;
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    halted_d      = halted_q;
    illegal_err_d = illegal_err_q;
    stall_cnt_d   = stall_cnt_q;

    if (!dc_wait) begin
      sb_d[2] = sb_q[1];
      sb_d[1] = sb_q[0];
      sb_d[0] = '0;
      if (run && !stall && !trap) begin
        sb_d[0].vld     = id_reg_wen & (id_rd != 5'd0);
        sb_d[0].rd      = id_rd;
        sb_d[0].is_load = (id_opcode_class == CLS_LOAD);
      end

      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end

      case (state_q)
        ST_RUN: begin
          if (trap && !stall) begin
            state_d       = ST_DRAIN;
            drain_cnt_d   = DCNT_W'(DRAIN_CYCLES);
            illegal_err_d = id_illegal_instr;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == DCNT_W'(1)) begin
            state_d     = ST_HALTED;
            drain_cnt_d = '0;
            halted_d    = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q - DCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) sb_q[i] <= '0;
      state_q       <= ST_RUN;
      drain_cnt_q   <= '0;
      halted_q      <= 1'b0;
      illegal_err_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) sb_q[i] <= sb_d[i];
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      halted_q      <= halted_d;
      illegal_err_q <= illegal_err_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign halted      = halted_q;
  assign illegal_err = illegal_err_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// Bench for dlx_hazard_ctrl: directed vector table, trap/reset sequences and
// randomized stimulus against an in-flight-destination reference model.
module tb_dlx_hazard_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int CNT_MAX = 15;

  localparam logic [2:0] C_RR = 3'd0;
  localparam logic [2:0] C_IM = 3'd1;
  localparam logic [2:0] C_LD = 3'd2;
  localparam logic [2:0] C_ST = 3'd3;
  localparam logic [2:0] C_BR = 3'd4;
  localparam logic [2:0] C_NF = 3'd5;

  logic             clk;
  logic             rst;
  logic             dc_wait;
  logic [2:0]       id_opcode_class;
  logic [4:0]       id_ir_rs1, id_ir_rs2, id_rd;
  logic             id_reg_wen, id_cond, id_halt, id_illegal_instr;
  logic             stall, id_a_fwd_sel, if_flush, if_hold, halted, illegal_err;
  logic [CNT_W-1:0] stall_cnt;

  dlx_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .dc_wait          (dc_wait),
    .id_opcode_class  (id_opcode_class),
    .id_ir_rs1        (id_ir_rs1),
    .id_ir_rs2        (id_ir_rs2),
    .id_rd            (id_rd),
    .id_reg_wen       (id_reg_wen),
    .id_cond          (id_cond),
    .id_halt          (id_halt),
    .id_illegal_instr (id_illegal_instr),
    .stall            (stall),
    .id_a_fwd_sel     (id_a_fwd_sel),
    .if_flush         (if_flush),
    .if_hold          (if_hold),
    .halted           (halted),
    .illegal_err      (illegal_err),
    .stall_cnt        (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input int a, input int b, input int d,
                       input logic w, input logic cd, input logic h, input logic il,
                       input logic dw);
    id_opcode_class  = c;
    id_ir_rs1        = 5'(a);
    id_ir_rs2        = 5'(b);
    id_rd            = 5'(d);
    id_reg_wen       = w;
    id_cond          = cd;
    id_halt          = h;
    id_illegal_instr = il;
    dc_wait          = dw;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [2:0] cls;
    logic [4:0] rs1, rs2, rd;
    logic       wen, cond, dcw;
    logic       e_stall, e_fwd, e_flush, e_hold;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] c, input int a, input int b, input int d,
                              input int w, input int cd, input int dw,
                              input int s, input int f, input int fl, input int h);
    vec_t v;
    v.cls = c;       v.rs1 = 5'(a);    v.rs2 = 5'(b);     v.rd = 5'(d);
    v.wen = 1'(w);   v.cond = 1'(cd);  v.dcw = 1'(dw);
    v.e_stall = 1'(s); v.e_fwd = 1'(f); v.e_flush = 1'(fl); v.e_hold = 1'(h);
    return v;
  endfunction

  localparam int NVEC = 20;
  vec_t tbl [NVEC];
  logic dw_pat [5];

  // Reference model: destination register of the producer at pipeline distance
  // 1 (EX), 2 (MEM), 3 (WB); 0 means nothing that can ever be a hazard.
  int m_rd [3];
  bit m_ld [3];
  int m_mode;      // 0 run, 1 draining, 2 stopped
  int m_left;
  bit m_halted, m_ill;
  int m_cnt;
  bit e_stall, e_fwd, e_flush, e_hold;

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_rd[i] = 0;
      m_ld[i] = 1'b0;
    end
    m_mode = 0; m_left = 0; m_halted = 1'b0; m_ill = 1'b0; m_cnt = 0;
  endtask

  task automatic m_eval();
    int c, a, b;
    bit u1, u2, run, need_ex;
    c = int'(id_opcode_class); a = int'(id_ir_rs1); b = int'(id_ir_rs2);
    u1  = (c <= 4);
    u2  = (c == 0) || (c == 3);
    run = (m_mode == 0);
    need_ex = (m_rd[0] != 0) && ((u1 && m_rd[0] == a) || (u2 && m_rd[0] == b));
    e_stall = run && ((m_ld[0] && need_ex)
                      || (c == 4 && a != 0 && m_rd[0] == a)
                      || (c == 4 && a != 0 && m_ld[1] && m_rd[1] == a));
    e_fwd   = (a != 0) && (m_rd[1] == a) && !m_ld[1];
    e_flush = id_cond && !e_stall && !dc_wait && run;
    e_hold  = e_stall || dc_wait || !run;
  endtask

  task automatic m_step();
    bit run, trap;
    run  = (m_mode == 0);
    trap = id_halt || id_illegal_instr;
    if (!dc_wait) begin
      m_rd[2] = m_rd[1]; m_ld[2] = m_ld[1];
      m_rd[1] = m_rd[0]; m_ld[1] = m_ld[0];
      if (run && !e_stall && !trap && id_reg_wen && id_rd != 5'd0) begin
        m_rd[0] = int'(id_rd);
        m_ld[0] = (id_opcode_class == C_LD);
      end else begin
        m_rd[0] = 0;
        m_ld[0] = 1'b0;
      end
      if (e_stall && m_cnt < CNT_MAX) m_cnt++;
      if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 2;
          m_halted = 1'b1;
        end
      end else if (run && trap && !e_stall) begin
        m_mode = 1;
        m_left = 3;
        m_ill  = id_illegal_instr;
      end
    end
  endtask

  initial begin
    tbl[0]  = mk(C_LD, 1, 0, 3, 1, 0, 0,  0, 0, 0, 0);
    tbl[1]  = mk(C_RR, 3, 5, 4, 1, 0, 0,  1, 0, 0, 1);
    tbl[2]  = mk(C_RR, 3, 5, 4, 1, 0, 0,  0, 0, 0, 0);
    tbl[3]  = mk(C_IM, 0, 0, 2, 1, 0, 0,  0, 0, 0, 0);
    tbl[4]  = mk(C_BR, 2, 0, 0, 0, 0, 0,  1, 0, 0, 1);
    tbl[5]  = mk(C_BR, 2, 0, 0, 0, 0, 1,  0, 1, 0, 1);
    tbl[6]  = mk(C_BR, 2, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    tbl[7]  = mk(C_LD, 0, 0, 7, 1, 0, 0,  0, 0, 0, 0);
    tbl[8]  = mk(C_BR, 7, 0, 0, 0, 1, 0,  1, 0, 0, 1);
    tbl[9]  = mk(C_BR, 7, 0, 0, 0, 1, 0,  1, 0, 0, 1);
    tbl[10] = mk(C_BR, 7, 0, 0, 0, 1, 1,  0, 0, 0, 1);
    tbl[11] = mk(C_BR, 7, 0, 0, 0, 1, 0,  0, 0, 1, 0);
    tbl[12] = mk(C_RR, 1, 2, 0, 1, 0, 0,  0, 0, 0, 0);
    tbl[13] = mk(C_RR, 0, 0, 6, 1, 0, 0,  0, 0, 0, 0);
    tbl[14] = mk(C_LD, 0, 0, 9, 1, 0, 0,  0, 0, 0, 0);
    tbl[15] = mk(C_ST, 0, 9, 0, 0, 0, 0,  1, 0, 0, 1);
    tbl[16] = mk(C_ST, 0, 9, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[17] = mk(C_IM, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(C_NF, 10, 10, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk(C_RR, 10, 0, 11, 1, 0, 0, 0, 1, 0, 0);
    dw_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b0;
    drive(C_NF, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd", 32'(id_a_fwd_sel), 0);
    chk("rst_flush", 32'(if_flush), 0);
    chk("rst_hold", 32'(if_hold), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_illegal", 32'(illegal_err), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // directed vector table
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].cls, int'(tbl[i].rs1), int'(tbl[i].rs2), int'(tbl[i].rd),
            tbl[i].wen, tbl[i].cond, 1'b0, 1'b0, tbl[i].dcw);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d_fwd", i), 32'(id_a_fwd_sel), 32'(tbl[i].e_fwd));
      chk($sformatf("vec%0d_flush", i), 32'(if_flush), 32'(tbl[i].e_flush));
      chk($sformatf("vec%0d_hold", i), 32'(if_hold), 32'(tbl[i].e_hold));
      @(posedge clk); #1;
      if (i == 1) chk("vec_cnt_after_loaduse", 32'(stall_cnt), 1);
    end
    chk("vec_cnt_final", 32'(stall_cnt), 5);

    // trap with two frozen cycles while draining
    drive(C_NF, 0, 0, 0, 0, 0, 0, 0, 0);
    pulse_reset();
    drive(C_NF, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("trap_decode_stall", 32'(stall), 0);
    chk("trap_decode_hold", 32'(if_hold), 0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      drive(C_LD, 3, 3, 3, 1, 1, 0, 0, dw_pat[k]);
      @(negedge clk);
      chk($sformatf("trap_drain%0d_halted", k), 32'(halted), 0);
      chk($sformatf("trap_drain%0d_hold", k), 32'(if_hold), 1);
      chk($sformatf("trap_drain%0d_flush", k), 32'(if_flush), 0);
      @(posedge clk); #1;
    end
    drive(C_RR, 3, 3, 4, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk("trap_halted", 32'(halted), 1);
    chk("trap_illegal", 32'(illegal_err), 0);
    chk("trap_hold", 32'(if_hold), 1);
    chk("trap_stall", 32'(stall), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("trap_halted_sticky", 32'(halted), 1);

    // simultaneous halt+illegal, then asynchronous reset mid-drain
    @(posedge clk); #1;
    drive(C_NF, 0, 0, 0, 0, 0, 0, 0, 0);
    pulse_reset();
    drive(C_RR, 0, 0, 0, 0, 0, 1, 1, 0);
    @(posedge clk); #1;
    drive(C_NF, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ill_err_set", 32'(illegal_err), 1);
    chk("ill_drain_hold", 32'(if_hold), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ill_rst_err", 32'(illegal_err), 0);
    chk("ill_rst_halted", 32'(halted), 0);
    chk("ill_rst_hold", 32'(if_hold), 0);
    chk("ill_rst_cnt", 32'(stall_cnt), 0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("ill_after%0d_halted", k), 32'(halted), 0);
      chk($sformatf("ill_after%0d_hold", k), 32'(if_hold), 0);
    end

    // randomized stimulus against the reference model
    @(posedge clk); #1;
    pulse_reset();
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 119) == 0) begin
        pulse_reset();
        m_reset();
      end
      drive(3'($urandom_range(0, 6)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 79) == 0), ($urandom_range(0, 149) == 0),
            ($urandom_range(0, 5) == 0));
      @(negedge clk);
      m_eval();
      chk("rnd_stall", 32'(stall), 32'(e_stall));
      chk("rnd_fwd", 32'(id_a_fwd_sel), 32'(e_fwd));
      chk("rnd_flush", 32'(if_flush), 32'(e_flush));
      chk("rnd_hold", 32'(if_hold), 32'(e_hold));
      chk("rnd_halted", 32'(halted), 32'(m_halted));
      chk("rnd_illegal", 32'(illegal_err), 32'(m_ill));
      chk("rnd_cnt", 32'(stall_cnt), 32'(m_cnt));
      m_step();
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
